ingress_voq_cell: RTL and testbench

- Parametrised ingress port for the crossbar switch.
- Accepts variable-length packets from the packet generator and segments them into fixed-size cells.
- Buffers cells in a shared block memory, kept as per-egress linked-list VOQs with a free-block allocator.
- Streams exactly one cell per scheduler grant towards the crossbar. Generalises the single-port, 4-VOQ ingress to N egresses, configurable cell/buffer sizing, length-based admission and drop accounting.

---
 rtl/ingress_voq_cell_if.sv | 43 ++++
 rtl/ingress_voq_cell.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_ingress_voq_cell.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ingress_voq_cell_if.sv
// rtl/ingress_voq_cell_if.sv - packet ingress, scheduler grant and cell egress handshakes
//
// Signals (master = packet source / scheduler / crossbar side, slave = ingress_voq_cell):
//   in_valid, in_sop, in_dest, in_len, in_data  : packet words towards the ingress
//   in_ready                                    : word accepted when in_valid && in_ready
//   grant_valid, grant_sel                      : scheduler grant for one cell of a VOQ
//   grant_ready                                 : output engine idle, a grant will be taken
//   out_valid, out_data, out_first, out_last,
//   out_eop                                     : cell words towards the crossbar
interface ingress_voq_cell_if #(
  parameter int N_EGRESS = 4,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 6
);
  localparam int DEST_W = $clog2(N_EGRESS);

  logic              in_valid;
  logic              in_sop;
  logic [DEST_W-1:0] in_dest;
  logic [LEN_W-1:0]  in_len;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic              grant_valid;
  logic [DEST_W-1:0] grant_sel;
  logic              grant_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_first;
  logic              out_last;
  logic              out_eop;

  modport master (
    output in_valid, in_sop, in_dest, in_len, in_data, grant_valid, grant_sel,
    input  in_ready, grant_ready, out_valid, out_data, out_first, out_last, out_eop
  );

  modport slave (
    input  in_valid, in_sop, in_dest, in_len, in_data, grant_valid, grant_sel,
    output in_ready, grant_ready, out_valid, out_data, out_first, out_last, out_eop
  );
endinterface

// File: rtl/ingress_voq_cell.sv
// rtl/ingress_voq_cell.sv - ingress port: packet segmentation into cells, shared-buffer VOQs, grant-driven cell egress
//
// Ports:
//   clk, reset    : clock; synchronous active-high reset (discards all buffered data, restarts INIT)
//   bus           : ingress_voq_cell_if.slave - packet input, scheduler grant, cell output
//   voq_nonempty  : bit i set when VOQ i holds at least one complete cell
//   drop_count    : packets refused for lack of buffer space, saturating
//   free_blocks   : free blocks not yet reserved by an admitted packet
//   voq_depth     : (only with VOQ_STATS_EN defined) complete cells per VOQ, flattened, VOQ 0 in LSBs
//
// Optional feature macro: VOQ_STATS_EN
module ingress_voq_cell #(
  parameter int N_EGRESS    = 4,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 8,
  parameter int N_BLOCKS    = 64,
  parameter int LEN_W       = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  ingress_voq_cell_if.slave             bus,
  output logic [N_EGRESS-1:0]           voq_nonempty,
  output logic [15:0]                   drop_count,
  output logic [$clog2(N_BLOCKS):0]     free_blocks
`ifdef VOQ_STATS_EN
  ,
  output logic [N_EGRESS*($clog2(N_BLOCKS)+1)-1:0] voq_depth
`endif
);
  localparam int DEST_W = $clog2(N_EGRESS);
  localparam int BLK_W  = $clog2(N_BLOCKS);
  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int CNT_W  = BLK_W + 1;
  localparam int WC_W   = OFF_W + 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IN_IDLE, IN_WRITE, IN_DROP} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_HEAD, OUT_STREAM} out_state_t;

  // Storage: cell data, per-block next pointer and {eop, word_count}, free-block FIFO
  logic [DATA_W-1:0] data_mem [N_BLOCKS*BLOCK_WORDS];
  logic [BLK_W-1:0]  next_mem [N_BLOCKS];
  logic [WC_W:0]     meta_mem [N_BLOCKS];
  logic [BLK_W-1:0]  free_mem [N_BLOCKS];

  logic              init_busy;
  logic [BLK_W-1:0]  init_idx;
  logic [BLK_W-1:0]  free_rd, free_wr;
  logic [BLK_W-1:0]  free_head;
  logic              push, pop;
  logic [BLK_W-1:0]  push_blk;

  in_state_t         in_state, in_state_nx;
  logic [BLK_W-1:0]  cur_blk, blk_nx;
  logic [OFF_W-1:0]  cur_off, off_nx;
  logic [LEN_W-1:0]  remaining, rem_nx;
  logic [DEST_W-1:0] cur_dest, dest_nx;

  logic              acc, fits, dest_ok, admit, drop;
  logic [LEN_W-1:0]  len_eff;
  logic [LEN_W:0]    needed;

  logic                    dmem_we;
  logic [BLK_W+OFF_W-1:0]  dmem_addr;

  logic              link_v, link_eop;
  logic [BLK_W-1:0]  link_blk;
  logic [WC_W-1:0]   link_wc;
  logic [DEST_W-1:0] link_dest;

  logic [BLK_W-1:0]  head [N_EGRESS];
  logic [BLK_W-1:0]  tail [N_EGRESS];
  logic [N_EGRESS-1:0] link_hit, deq_hit;

  out_state_t        out_state, out_state_nx;
  logic              grant_take, sel_ok, free_ev;
  logic [BLK_W-1:0]  out_blk;
  logic [OFF_W-1:0]  rd_off;
  logic [WC_W-1:0]   out_wc, head_wc;
  logic              out_meop, head_eop, stream_last;

  // ---------------- free-block FIFO and INIT ----------------
  assign free_head = free_mem[free_rd];
  assign push      = init_busy || free_ev;
  assign push_blk  = init_busy ? init_idx : out_blk;

  always_ff @(posedge clk) begin
    if (reset) begin
      init_busy <= 1'b1;
      init_idx  <= '0;
      free_rd   <= '0;
      free_wr   <= '0;
    end else begin
      if (init_busy) begin
        init_idx <= init_idx + BLK_W'(1);
        if (init_idx == BLK_W'(N_BLOCKS - 1)) init_busy <= 1'b0;
      end
      if (push) free_wr <= free_wr + BLK_W'(1);
      if (pop)  free_rd <= free_rd + BLK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) free_mem[free_wr] <= push_blk;
  end

  // Admission compares against the registered count, so a same-cycle free is not yet visible.
  always_ff @(posedge clk) begin
    if (reset) free_blocks <= '0;
    else       free_blocks <= free_blocks - (admit ? CNT_W'(needed) : '0) + (push ? CNT_W'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset)                             drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end

  // ---------------- input FSM ----------------
  assign bus.in_ready = !init_busy;
  assign acc     = bus.in_valid && bus.in_ready;
  assign len_eff = (bus.in_len == '0) ? LEN_W'(1) : bus.in_len;
  assign needed  = ({1'b0, len_eff} + (LEN_W+1)'(BLOCK_WORDS - 1)) >> OFF_W;
  // A destination beyond the last VOQ has nowhere to be linked, so it is refused like a full buffer.
  assign dest_ok = int'(bus.in_dest) < N_EGRESS;
  assign fits    = dest_ok && (int'(free_blocks) >= int'(needed));

  always_ff @(posedge clk) begin
    if (reset) begin
      in_state  <= IN_IDLE;
      cur_blk   <= '0;
      cur_off   <= '0;
      remaining <= '0;
      cur_dest  <= '0;
    end else begin
      in_state  <= in_state_nx;
      cur_blk   <= blk_nx;
      cur_off   <= off_nx;
      remaining <= rem_nx;
      cur_dest  <= dest_nx;
    end
  end

  always_comb begin
    in_state_nx = in_state;
    blk_nx      = cur_blk;
    off_nx      = cur_off;
    rem_nx      = remaining;
    dest_nx     = cur_dest;
    pop         = 1'b0;
    admit       = 1'b0;
    drop        = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = {cur_blk, cur_off};
    link_v      = 1'b0;
    link_blk    = cur_blk;
    link_wc     = '0;
    link_eop    = 1'b0;
    link_dest   = cur_dest;
    case (in_state)
      IN_IDLE: begin
        if (acc && bus.in_sop) begin
          rem_nx = len_eff - LEN_W'(1);
          if (fits) begin
            admit     = 1'b1;
            pop       = 1'b1;
            dmem_we   = 1'b1;
            dmem_addr = {free_head, OFF_W'(0)};
            blk_nx    = free_head;
            off_nx    = OFF_W'(1);
            dest_nx   = bus.in_dest;
            if (len_eff == LEN_W'(1)) begin
              link_v    = 1'b1;
              link_blk  = free_head;
              link_wc   = WC_W'(1);
              link_eop  = 1'b1;
              link_dest = bus.in_dest;
            end else begin
              in_state_nx = IN_WRITE;
            end
          end else begin
            drop = 1'b1;
            if (len_eff != LEN_W'(1)) in_state_nx = IN_DROP;
          end
        end
      end
      IN_WRITE: begin
        // in_sop here is just data; only the length counter ends the packet.
        if (acc) begin
          rem_nx  = remaining - LEN_W'(1);
          dmem_we = 1'b1;
          off_nx  = cur_off + OFF_W'(1);
          if (cur_off == LAST_OFF || rem_nx == '0) begin
            link_v   = 1'b1;
            link_wc  = WC_W'(cur_off) + WC_W'(1);
            link_eop = (rem_nx == '0);
          end
          if (rem_nx == '0) begin
            in_state_nx = IN_IDLE;
          end else if (cur_off == LAST_OFF) begin
            pop    = 1'b1;
            blk_nx = free_head;
          end
        end
      end
      IN_DROP: begin
        if (acc) begin
          rem_nx = remaining - LEN_W'(1);
          if (rem_nx == '0) in_state_nx = IN_IDLE;
        end
      end
      default: in_state_nx = IN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (dmem_we) data_mem[dmem_addr] <= bus.in_data;
  end

  // ---------------- VOQ linked lists ----------------
  assign sel_ok     = int'(bus.grant_sel) < N_EGRESS;
  assign grant_take = bus.grant_valid && bus.grant_ready && sel_ok && voq_nonempty[bus.grant_sel];

  always_comb begin
    link_hit = '0;
    deq_hit  = '0;
    for (int q = 0; q < N_EGRESS; q++) begin
      link_hit[q] = link_v && (int'(link_dest) == q);
      deq_hit[q]  = grant_take && (int'(bus.grant_sel) == q);
    end
  end

  always_ff @(posedge clk) begin
    if (link_v) begin
      meta_mem[link_blk] <= {link_eop, link_wc};
      if (voq_nonempty[link_dest]) next_mem[tail[link_dest]] <= link_blk;
    end
  end

  // head == tail on a non-empty VOQ means it holds exactly one cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      voq_nonempty <= '0;
      for (int q = 0; q < N_EGRESS; q++) begin
        head[q] <= '0;
        tail[q] <= '0;
      end
    end else begin
      for (int q = 0; q < N_EGRESS; q++) begin
        if (deq_hit[q] && link_hit[q]) begin
          // The old next pointer of a lone head is not written yet, so take the new cell directly.
          head[q] <= (head[q] == tail[q]) ? link_blk : next_mem[head[q]];
          tail[q] <= link_blk;
        end else if (deq_hit[q]) begin
          if (head[q] == tail[q]) voq_nonempty[q] <= 1'b0;
          else                    head[q] <= next_mem[head[q]];
        end else if (link_hit[q]) begin
          if (!voq_nonempty[q]) begin
            head[q]         <= link_blk;
            voq_nonempty[q] <= 1'b1;
          end
          tail[q] <= link_blk;
        end
      end
    end
  end

`ifdef VOQ_STATS_EN
  logic [CNT_W-1:0] depth [N_EGRESS];

  always_ff @(posedge clk) begin
    for (int q = 0; q < N_EGRESS; q++) begin
      if (reset)                        depth[q] <= '0;
      else if (link_hit[q] && !deq_hit[q]) depth[q] <= depth[q] + CNT_W'(1);
      else if (deq_hit[q] && !link_hit[q]) depth[q] <= depth[q] - CNT_W'(1);
    end
  end

  always_comb begin
    voq_depth = '0;
    for (int q = 0; q < N_EGRESS; q++) voq_depth[q*CNT_W +: CNT_W] = depth[q];
  end
`endif

  // ---------------- output FSM ----------------
  assign bus.grant_ready = !init_busy && (out_state == OUT_IDLE);
  assign free_ev     = (out_state == OUT_STREAM) && bus.out_last;
  assign head_wc     = meta_mem[out_blk][WC_W-1:0];
  assign head_eop    = meta_mem[out_blk][WC_W];
  assign stream_last = (WC_W'(rd_off) + WC_W'(1)) == out_wc;

  always_ff @(posedge clk) begin
    if (reset) out_state <= OUT_IDLE;
    else       out_state <= out_state_nx;
  end

  always_comb begin
    out_state_nx = out_state;
    case (out_state)
      OUT_IDLE:   if (grant_take) out_state_nx = OUT_HEAD;
      OUT_HEAD:   out_state_nx = OUT_STREAM;
      OUT_STREAM: if (bus.out_last) out_state_nx = OUT_IDLE;
      default:    out_state_nx = OUT_IDLE;
    endcase
  end

  // Registered read: the grant cycle latches the head block, HEAD fetches word 0, so out_first is two cycles after the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_blk       <= '0;
      rd_off        <= '0;
      out_wc        <= '0;
      out_meop      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_eop   <= 1'b0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (grant_take) out_blk <= head[bus.grant_sel];
        end
        OUT_HEAD: begin
          out_wc        <= head_wc;
          out_meop      <= head_eop;
          rd_off        <= OFF_W'(1);
          bus.out_valid <= 1'b1;
          bus.out_data  <= data_mem[{out_blk, OFF_W'(0)}];
          bus.out_first <= 1'b1;
          bus.out_last  <= (head_wc == WC_W'(1));
          bus.out_eop   <= head_eop && (head_wc == WC_W'(1));
        end
        OUT_STREAM: begin
          if (bus.out_last) begin
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_eop   <= 1'b0;
          end else begin
            rd_off        <= rd_off + OFF_W'(1);
            bus.out_data  <= data_mem[{out_blk, rd_off}];
            bus.out_first <= 1'b0;
            bus.out_last  <= stream_last;
            bus.out_eop   <= out_meop && stream_last;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ingress_voq_cell.sv
// tb/tb_ingress_voq_cell.sv - randomized self-checking bench for ingress_voq_cell against a queue-level reference model
module tb_ingress_voq_cell;
  localparam int N_EGRESS    = 4;
  localparam int DATA_W      = 32;
  localparam int BLOCK_WORDS = 8;
  localparam int N_BLOCKS    = 64;
  localparam int LEN_W       = 6;
  localparam int DEST_W      = $clog2(N_EGRESS);
  localparam int CNT_W       = $clog2(N_BLOCKS) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ingress_voq_cell_if #(.N_EGRESS(N_EGRESS), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  logic [N_EGRESS-1:0] voq_nonempty;
  logic [15:0]         drop_count;
  logic [CNT_W-1:0]    free_blocks;
`ifdef VOQ_STATS_EN
  logic [N_EGRESS*CNT_W-1:0] voq_depth;
`endif

  ingress_voq_cell #(
    .N_EGRESS(N_EGRESS), .DATA_W(DATA_W), .BLOCK_WORDS(BLOCK_WORDS),
    .N_BLOCKS(N_BLOCKS), .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .voq_nonempty(voq_nonempty),
    .drop_count(drop_count),
    .free_blocks(free_blocks)
`ifdef VOQ_STATS_EN
    ,
    .voq_depth(voq_depth)
`endif
  );

  // Reference model: each VOQ is a FIFO of cells (word count, eop flag) plus a flat FIFO of their words.
  int tests = 0;
  int fails = 0;
  int mfree;
  int mdrop;
  logic [DATA_W-1:0] vq_words [N_EGRESS][$];
  int                vq_cnt   [N_EGRESS][$];
  bit                vq_eop   [N_EGRESS][$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_EGRESS-1:0] model_nonempty();
    logic [N_EGRESS-1:0] r;
    for (int q = 0; q < N_EGRESS; q++) r[q] = (vq_cnt[q].size() != 0);
    return r;
  endfunction

  task automatic model_clear();
    for (int q = 0; q < N_EGRESS; q++) begin
      vq_words[q].delete();
      vq_cnt[q].delete();
      vq_eop[q].delete();
    end
    mfree = N_BLOCKS;
    mdrop = 0;
  endtask

  task automatic check_state();
    check("free_blocks", free_blocks, mfree);
    check("voq_nonempty", voq_nonempty, model_nonempty());
    check("drop_count", drop_count, mdrop);
`ifdef VOQ_STATS_EN
    for (int q = 0; q < N_EGRESS; q++)
      check("voq_depth", voq_depth[q*CNT_W +: CNT_W], vq_cnt[q].size());
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    check("init_in_ready", bus.in_ready, 1'b0);
    check("init_free_blocks", free_blocks, 0);
    repeat (N_BLOCKS) tick();
  endtask

  task automatic send_pkt(input int dest, input int len, input bit gaps,
                          input bit use_base, input logic [DATA_W-1:0] base);
    int leff;
    int need;
    int i;
    int n;
    int cyc;
    bit acc;
    logic [DATA_W-1:0] w [$];
    leff = (len == 0) ? 1 : len;
    need = (leff + BLOCK_WORDS - 1) / BLOCK_WORDS;
    for (int k = 0; k < leff; k++) w.push_back(use_base ? base + DATA_W'(k) : DATA_W'($urandom));
    if (need <= mfree) begin
      mfree -= need;
      for (int c = 0; c < leff; c += BLOCK_WORDS) begin
        n = (leff - c < BLOCK_WORDS) ? leff - c : BLOCK_WORDS;
        for (int k = 0; k < n; k++) vq_words[dest].push_back(w[c+k]);
        vq_cnt[dest].push_back(n);
        vq_eop[dest].push_back(c + n == leff);
      end
    end else begin
      mdrop++;
    end
    i = 0;
    cyc = 0;
    while (i < leff && cyc < 1000) begin
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_sop   = (i == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      bus.in_dest  = DEST_W'(dest);
      bus.in_len   = LEN_W'(len);
      bus.in_data  = w[i];
      acc = bus.in_valid && bus.in_ready;
      tick();
      cyc++;
      if (acc) i++;
    end
    check("send_timeout", (i == leff), 1'b1);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  task automatic do_grant(input int sel);
    int n;
    int cnt;
    bit eop;
    n = 0;
    while (!bus.grant_ready && n < 100) begin
      tick();
      n++;
    end
    check("grant_ready_wait", (n < 100), 1'b1);
    bus.grant_valid = 1'b1;
    bus.grant_sel   = DEST_W'(sel);
    tick();
    bus.grant_valid = 1'b0;
    if (vq_cnt[sel].size() == 0) begin
      for (int k = 0; k < 10; k++) begin
        check("empty_grant_out_valid", bus.out_valid, 1'b0);
        check("empty_grant_ready", bus.grant_ready, 1'b1);
        tick();
      end
    end else begin
      cnt = vq_cnt[sel].pop_front();
      eop = vq_eop[sel].pop_front();
      check("head_latency_gap", bus.out_valid, 1'b0);
      tick();
      for (int k = 0; k < cnt; k++) begin
        check("out_valid", bus.out_valid, 1'b1);
        check("out_first", bus.out_first, (k == 0));
        check("out_data", bus.out_data, vq_words[sel].pop_front());
        check("out_last", bus.out_last, (k == cnt - 1));
        check("out_eop", bus.out_eop, eop && (k == cnt - 1));
        tick();
      end
      check("out_idle_after_cell", bus.out_valid, 1'b0);
      mfree++;
    end
  endtask

  task automatic drain_all();
    for (int q = 0; q < N_EGRESS; q++)
      while (vq_cnt[q].size() != 0) do_grant(q);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_sop      = 1'b0;
    bus.in_dest     = '0;
    bus.in_len      = '0;
    bus.in_data     = '0;
    bus.grant_valid = 1'b0;
    bus.grant_sel   = '0;

    // Reset and INIT window: in_ready low for the first N_BLOCKS cycles after release.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_nonempty", voq_nonempty, 0);
    check("reset_drop", drop_count, 0);
    check("reset_free", free_blocks, 0);
    for (int k = 1; k <= 70; k++) begin
      check("init_in_ready", bus.in_ready, (k > N_BLOCKS));
      check("init_grant_ready", bus.grant_ready, (k > N_BLOCKS));
      tick();
    end
    check("free_after_init", free_blocks, N_BLOCKS);

    // Stray word without sop is discarded, then an 8-word packet to VOQ 2.
    bus.in_valid = 1'b1;
    bus.in_sop   = 1'b0;
    bus.in_data  = 32'hDEAD_BEEF;
    tick();
    bus.in_valid = 1'b0;
    send_pkt(2, 8, 1'b0, 1'b1, 32'h100);
    tick();
    check("free_after_admit", free_blocks, 63);
    check_state();
    do_grant(2);
    check("free_after_return", free_blocks, 64);
    check_state();

    // 19-word packet: cells of 8, 8, 3; eop only on the third.
    send_pkt(1, 19, 1'b1, 1'b1, 32'h200);
    tick();
    check_state();
    for (int g = 0; g < 3; g++) begin
      do_grant(1);
      check("voq1_nonempty", voq_nonempty[1], (g < 2));
    end

    // Grant to an empty VOQ produces nothing.
    do_grant(3);
    check_state();

    // Link to VOQ 0 in the same cycle its only cell is dequeued.
    send_pkt(0, 8, 1'b0, 1'b1, 32'h300);
    tick();
    fork
      begin
        send_pkt(0, 4, 1'b0, 1'b1, 32'h400);
      end
      begin
        repeat (3) tick();
        do_grant(0);
      end
    join
    check_state();
    do_grant(0);
    check_state();

    // Fill the whole buffer, then one more packet must be refused.
    for (int p = 0; p < 8; p++) send_pkt(0, 63, 1'b0, 1'b0, '0);
    tick();
    check("full_free", free_blocks, 0);
    send_pkt(1, 1, 1'b0, 1'b0, '0);
    tick();
    check("full_drop", drop_count, 1);
    check_state();
    drain_all();
    check_state();

    // Reset with data buffered discards everything.
    send_pkt(3, 10, 1'b1, 1'b0, '0);
    do_reset();
    check("midreset_free", free_blocks, N_BLOCKS);
    check_state();

    // Randomized mix of packets (lengths 0..63, random gaps, stray sops) and grants.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 0)
        send_pkt($urandom_range(0, N_EGRESS - 1), $urandom_range(0, 63), 1'b1, 1'b0, '0);
      else
        do_grant($urandom_range(0, N_EGRESS - 1));
      tick();
      check_state();
    end
    drain_all();
    tick();
    check_state();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
